// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: EX/MEM in, req/ack data bus, registered MEM/WB out.
// Optional misaligned-access trapping is enabled by defining MISALIGN_TRAP_EN.
module mem_stage_lsu #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk_I,
  input  logic        reset_I,
  input  logic [31:0] aluResult_I,
  input  logic [31:0] rs2Data_I,
  input  logic [2:0]  func3_I,
  input  logic        memReadEnable_I,
  input  logic        memWriteEn_I,
  input  logic        reg_W_En_I,
  input  logic [4:0]  rdAddr_I,
  input  logic [1:0]  destRegWriteSel_I,
  input  logic [31:0] currInstructionAddrPlus4_I,
  output logic        stall_O,
  output logic        dmemReq_O,
  output logic        dmemWe_O,
  output logic [31:0] dmemAddr_O,
  output logic [31:0] dmemWData_O,
  output logic [3:0]  dmemStrb_O,
  input  logic        dmemAck_I,
  input  logic [31:0] dmemRData_I,
  output logic        wbValid_O,
  output logic        wbRegWEn_O,
  output logic [4:0]  wbRdAddr_O,
  output logic [1:0]  wbDestSel_O,
  output logic [31:0] wbAluResult_O,
  output logic [31:0] wbLoadData_O,
  output logic [31:0] wbPcPlus4_O,
  output logic        excValid_O,
  output logic [1:0]  excCause_O,
  output logic [31:0] excAddr_O
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;
  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

  logic [0:0]  state;
  logic [7:0]  to_cnt;
  logic [31:0] acc_addr, acc_pc4;
  logic [2:0]  acc_func3;
  logic        acc_store, acc_regwen;
  logic [4:0]  acc_rd;
  logic [1:0]  acc_destsel;

  logic        is_mem, misalign, start_access, ack_hit, timeout_hit;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata;

  assign is_mem = memReadEnable_I | memWriteEn_I;

`ifdef MISALIGN_TRAP_EN
  logic half_acc, word_acc;
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    half_acc = memWriteEn_I ? (func3_I == 3'b001) : (func3_I[1:0] == 2'b01);
    word_acc = (func3_I == 3'b010);
    misalign = is_mem & ((half_acc & aluResult_I[0]) | (word_acc & (|aluResult_I[1:0])));
  end
`else
  assign misalign = 1'b0;
`endif

  assign start_access = (state == ST_IDLE) & is_mem & ~misalign;
  assign ack_hit      = (state == ST_BUSY) & dmemAck_I;
  assign timeout_hit  = (state == ST_BUSY) & ~dmemAck_I & (to_cnt == TIMEOUT_M1);
  // Upstream may advance in the same cycle the access resolves (ack or timeout).
  assign stall_O      = start_access | ((state == ST_BUSY) & ~ack_hit & ~timeout_hit);

  always_comb begin
    st_strb  = 4'b1111;
    st_wdata = rs2Data_I;
    case (func3_I)
      3'b000: begin
        st_strb  = 4'b0001 << aluResult_I[1:0];
        st_wdata = {4{rs2Data_I[7:0]}};
      end
      3'b001: begin
        st_strb  = 4'b0011 << {aluResult_I[1], 1'b0};
        st_wdata = {2{rs2Data_I[15:0]}};
      end
      default: ;
    endcase
  end

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lane,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  always_ff @(posedge clk_I or negedge reset_I) begin
    if (!reset_I) begin
      state         <= ST_IDLE;
      to_cnt        <= '0;
      acc_addr      <= '0;
      acc_pc4       <= '0;
      acc_func3     <= '0;
      acc_store     <= 1'b0;
      acc_regwen    <= 1'b0;
      acc_rd        <= '0;
      acc_destsel   <= '0;
      dmemReq_O     <= 1'b0;
      dmemWe_O      <= 1'b0;
      dmemAddr_O    <= '0;
      dmemWData_O   <= '0;
      dmemStrb_O    <= '0;
      wbValid_O     <= 1'b0;
      wbRegWEn_O    <= 1'b0;
      wbRdAddr_O    <= '0;
      wbDestSel_O   <= '0;
      wbAluResult_O <= '0;
      wbLoadData_O  <= '0;
      wbPcPlus4_O   <= '0;
      excValid_O    <= 1'b0;
      excCause_O    <= '0;
      excAddr_O     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments; these defaults are overridden below.
      wbValid_O  <= 1'b0;
      wbRegWEn_O <= 1'b0;
      excValid_O <= 1'b0;
      excCause_O <= '0;
      excAddr_O  <= '0;
      case (state)
        ST_IDLE: begin
          if (start_access) begin
            state       <= ST_BUSY;
            to_cnt      <= '0;
            dmemReq_O   <= 1'b1;
            dmemWe_O    <= memWriteEn_I;
            dmemAddr_O  <= {aluResult_I[31:2], 2'b00};
            dmemWData_O <= st_wdata;
            dmemStrb_O  <= memWriteEn_I ? st_strb : 4'b1111;
            acc_addr    <= aluResult_I;
            acc_pc4     <= currInstructionAddrPlus4_I;
            acc_func3   <= func3_I;
            acc_store   <= memWriteEn_I;
            acc_regwen  <= reg_W_En_I;
            acc_rd      <= rdAddr_I;
            acc_destsel <= destRegWriteSel_I;
          end else begin
            wbValid_O     <= 1'b1;
            wbRegWEn_O    <= reg_W_En_I & ~misalign;
            wbRdAddr_O    <= rdAddr_I;
            wbDestSel_O   <= destRegWriteSel_I;
            wbAluResult_O <= aluResult_I;
            wbLoadData_O  <= '0;
            wbPcPlus4_O   <= currInstructionAddrPlus4_I;
            excValid_O    <= misalign;
            excCause_O    <= misalign ? (memWriteEn_I ? 2'b10 : 2'b01) : 2'b00;
            excAddr_O     <= misalign ? aluResult_I : '0;
          end
        end
        default: begin
          if (ack_hit || timeout_hit) begin
            state         <= ST_IDLE;
            dmemReq_O     <= 1'b0;
            wbValid_O     <= 1'b1;
            wbRegWEn_O    <= ack_hit & acc_regwen & ~acc_store;
            wbRdAddr_O    <= acc_rd;
            wbDestSel_O   <= acc_destsel;
            wbAluResult_O <= acc_addr;
            wbPcPlus4_O   <= acc_pc4;
            wbLoadData_O  <= (ack_hit && !acc_store) ? extract(acc_func3, acc_addr[1:0], dmemRData_I) : '0;
            excValid_O    <= timeout_hit;
            excCause_O    <= timeout_hit ? 2'b11 : 2'b00;
            excAddr_O     <= timeout_hit ? acc_addr : '0;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule
